// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR multiply-accumulate engine.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_COEF_WIDTH = 18;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_NTAPS      = 256;
  localparam int DEF_OUT_WIDTH  = 24;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    OUT
  } state_t;

  // Accumulator wide enough to sum 2^addr full-scale products without overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int addr_w);
    return data_w + coef_w + addr_w;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Arithmetic shift with round-half-up, then clamp to the signed output range.
module fir_round_sat #(
  parameter int ACC_WIDTH = 50,
  parameter int OUT_WIDTH = 24,
  parameter int OUT_SHIFT = 17
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [W-1:0] MAXV = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [W-1:0] sum;
  logic signed [W-1:0] shifted;

  // Round, shift, saturate.
  always_comb begin
    sum     = W'(acc) + HALF;
    shifted = sum >>> OUT_SHIFT;
    if (shifted > MAXV)      out_data = MAXV[OUT_WIDTH-1:0];
    else if (shifted < MINV) out_data = MINV[OUT_WIDTH-1:0];
    else                     out_data = shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR MAC controller: writes each accepted sample to the circular
// buffer, walks NTAPS taps newest-to-oldest against a synchronous coefficient
// ROM, and emits one rounded/saturated output per sample.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NTAPS      = DEF_NTAPS,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, COEF_WIDTH, ADDR_WIDTH),
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int OUT_SHIFT  = COEF_WIDTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] buf_wdata,
  output logic                         buf_wren,
  output logic                         buf_rden,
  input  logic signed [DATA_WIDTH-1:0] buf_rdata,
  output logic        [ADDR_WIDTH-1:0] coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NTAPS - 1);

  state_t                 state;
  logic                   drain_cnt;
  logic                   d_valid, d_first;
  logic                   p_valid, p_first;
  logic signed [PW-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc, acc_next;
  logic signed [OUT_WIDTH-1:0] rs_out;

  assign in_ready = (state == IDLE);

  // The first product loads the accumulator, so no clear cycle is needed.
  always_comb begin
    acc_next = acc;
    if (p_valid) acc_next = p_first ? ACC_WIDTH'(prod) : acc + ACC_WIDTH'(prod);
  end

  // Output is formed from the value being loaded on the final accumulate edge,
  // so the registered out_data/out_valid line up with the OUT state.
  fir_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc      (acc_next),
    .out_data (rs_out)
  );

  // MAC pipeline: read data valid -> product register -> accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_valid <= 1'b0;
      d_first <= 1'b0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      prod    <= '0;
      acc     <= '0;
    end else begin
      d_valid <= buf_rden;
      d_first <= buf_rden && (coef_addr == '0);
      p_valid <= d_valid;
      p_first <= d_first;
      if (d_valid) prod <= buf_rdata * coef_data;
      acc <= acc_next;
    end
  end

  // Control FSM with registered strobes, tap counter and overrun flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      buf_wdata <= '0;
      buf_wren  <= 1'b0;
      buf_rden  <= 1'b0;
      coef_addr <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      buf_wren  <= 1'b0;
      out_valid <= 1'b0;
      if (in_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            buf_wdata <= in_data;
            buf_wren  <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          buf_rden  <= 1'b1;
          coef_addr <= '0;
          state     <= READ;
        end
        READ: begin
          if (coef_addr == LAST_TAP) begin
            buf_rden  <= 1'b0;
            coef_addr <= '0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            coef_addr <= coef_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            out_data  <= rs_out;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
